// File: rtl/j1_boot_loader_if.sv
// Byte-stream input and j1 program-memory write port of the boot loader.
// The loader binds to the slave modport; the byte source / memory side uses master.
interface j1_boot_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pgm_addr;
  logic [15:0] pgm_data;
  logic        pgm_we;

  modport master (
    output in_data, in_valid,
    input  in_ready, pgm_addr, pgm_data, pgm_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, pgm_addr, pgm_data, pgm_we
  );
endinterface

// File: rtl/j1_boot_loader.sv
// j1 boot sequencer: holds the CPU in reset, receives a framed, checksummed image
// from a byte stream, writes it into program memory and then releases the CPU.
module j1_boot_loader #(
  parameter int unsigned MAX_WORDS = 8192,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter bit          REARM     = 1'b1
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  j1_boot_loader_if.slave bus,
  output logic            cpu_rst_o,
  output logic            load_done,
  output logic            load_err
);

  typedef enum logic [2:0] {
    S_SYNC, S_CNTL, S_CNTH, S_DLO, S_DHI, S_CSUM, S_RUN
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  // Timer only has to hold 0..TIMEOUT-1; expiry is detected on the last count.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   index_q, index_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;

  logic          ready;
  logic          accept;
  logic          in_frame;
  logic [7:0]    sum_add;
  logic [15:0]   index_inc;
  logic [15:0]   count_new;

  always_comb begin
    ready     = !sys_rst_i && !(state_q == S_RUN && !REARM);
    accept    = bus.in_valid && ready;
    in_frame  = (state_q == S_CNTL) || (state_q == S_CNTH) || (state_q == S_DLO) ||
                (state_q == S_DHI)  || (state_q == S_CSUM);
    sum_add   = sum_q + bus.in_data;
    index_inc = index_q + 16'd1;
    count_new = {bus.in_data, count_q[7:0]};

    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    lo_d    = lo_q;
    sum_d   = sum_q;
    timer_d = in_frame ? timer_q + 1'b1 : '0;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (accept) begin
      timer_d = '0;
      case (state_q)
        S_SYNC, S_RUN: begin
          if (bus.in_data == SYNC_BYTE) begin
            err_d   = 1'b0;
            sum_d   = '0;
            index_d = '0;
            state_d = S_CNTL;
          end
        end
        S_CNTL: begin
          count_d[7:0] = bus.in_data;
          state_d      = S_CNTH;
        end
        S_CNTH: begin
          count_d = count_new;
          if (count_new == 16'd0 || 32'(count_new) > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end else begin
            state_d = S_DLO;
          end
        end
        S_DLO: begin
          lo_d    = bus.in_data;
          sum_d   = sum_add;
          state_d = S_DHI;
        end
        S_DHI: begin
          sum_d   = sum_add;
          we_d    = 1'b1;
          addr_d  = {index_q[14:0], 1'b0};
          data_d  = {bus.in_data, lo_q};
          index_d = index_inc;
          state_d = (index_inc < count_q) ? S_DLO : S_CSUM;
        end
        S_CSUM: begin
          if (sum_add == 8'h00) begin
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end else if (in_frame && TIMEOUT != 0 && timer_q == TLIM) begin
      err_d   = 1'b1;
      timer_d = '0;
      state_d = S_SYNC;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= S_SYNC;
      count_q <= '0;
      index_q <= '0;
      lo_q    <= '0;
      sum_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      lo_q    <= lo_d;
      sum_q   <= sum_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // CPU reset and done flag follow the RUN state directly, so they change on
  // the clock that enters or leaves RUN.
  assign cpu_rst_o    = (state_q != S_RUN);
  assign load_done    = (state_q == S_RUN);
  assign load_err     = err_q;
  assign bus.in_ready = ready;
  assign bus.pgm_we   = we_q;
  assign bus.pgm_addr = addr_q;
  assign bus.pgm_data = data_q;

endmodule

// File: tb/tb_j1_boot_loader.sv
// Bench for j1_boot_loader: frame vector table, directed corner sequences and
// random frames checked against a frame-level reference model.
module tb_j1_boot_loader;

  logic clk = 1'b0;
  logic rst;
  logic cpu_rst, done, err;

  j1_boot_loader_if bus ();

  j1_boot_loader #(
    .MAX_WORDS (8192),
    .TIMEOUT   (100),
    .REARM     (1'b1)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bus),
    .cpu_rst_o (cpu_rst),
    .load_done (done),
    .load_err  (err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] wr_q[$];
  int unsigned bad_we = 0;

  always @(negedge clk) begin
    if (bus.pgm_we === 1'b1) begin
      wr_q.push_back({bus.pgm_addr, bus.pgm_data});
      if (cpu_rst !== 1'b1) bad_we++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a byte and returns 1 time unit after the clock edge that takes it.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("in_ready for byte %h", b), {31'd0, got}, 32'd1);
    if (got) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, ".cpu_rst"},  {31'd0, cpu_rst},      32'd1);
    chk({tag, ".done"},     {31'd0, done},         32'd0);
    chk({tag, ".err"},      {31'd0, err},          32'd0);
    chk({tag, ".we"},       {31'd0, bus.pgm_we},   32'd0);
    chk({tag, ".addr"},     {16'd0, bus.pgm_addr}, 32'd0);
    chk({tag, ".data"},     {16'd0, bus.pgm_data}, 32'd0);
  endtask

  task automatic send_good_frame();
    logic [7:0] fr [8];
    fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEC};
    for (int i = 0; i < 8; i++) send_byte(fr[i]);
  endtask

  typedef struct {
    string           name;
    logic [15:0][7:0] b;     // first byte at index len-1
    int unsigned     len;
    int unsigned     nwr;
    logic [31:0]     w0;
    logic [31:0]     w1;
    logic            done;
    logic            err;
    logic            crst;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{"good", 128'({8'hA5,8'h02,8'h00,8'h34,8'h12,8'h78,8'h56,8'hEC}),
              8, 2, 32'h0000_1234, 32'h0002_5678, 1'b1, 1'b0, 1'b0};
    vt[1] = '{"bad_csum", 128'({8'hA5,8'h02,8'h00,8'h34,8'h12,8'h78,8'h56,8'hED}),
              8, 2, 32'h0000_1234, 32'h0002_5678, 1'b0, 1'b1, 1'b1};
    vt[2] = '{"hunt", 128'({8'h00,8'hFF,8'h5A,8'hA5,8'h02,8'h00,8'h34,8'h12,8'h78,8'h56,8'hEC}),
              11, 2, 32'h0000_1234, 32'h0002_5678, 1'b1, 1'b0, 1'b0};
    vt[3] = '{"count0", 128'({8'hA5,8'h00,8'h00}),
              3, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
    vt[4] = '{"count2001", 128'({8'hA5,8'h01,8'h20}),
              3, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
    vt[5] = '{"bad_then_good", {8'hA5,8'h02,8'h00,8'h34,8'h12,8'h78,8'h56,8'hED,
                                8'hA5,8'h02,8'h00,8'h34,8'h12,8'h78,8'h56,8'hEC},
              16, 4, 32'h0000_1234, 32'h0002_5678, 1'b1, 1'b0, 1'b0};
    vt[6] = '{"count2000", 128'({8'hA5,8'h00,8'h20}),
              3, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[7] = '{"count1", 128'({8'hA5,8'h01,8'h00,8'hCD,8'hAB,8'h88}),
              6, 1, 32'h0000_ABCD, 32'h0, 1'b1, 1'b0, 1'b0};

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Table-driven frames, each from a fresh reset.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int unsigned i = 0; i < vt[v].len; i++) send_byte(vt[v].b[vt[v].len - 1 - i]);
      idle(3);
      chk({vt[v].name, ".nwr"}, wr_q.size(), vt[v].nwr);
      if (vt[v].nwr >= 1 && wr_q.size() >= 1) chk({vt[v].name, ".w0"}, wr_q[0], vt[v].w0);
      if (vt[v].nwr >= 2 && wr_q.size() >= 2) chk({vt[v].name, ".w1"}, wr_q[1], vt[v].w1);
      chk({vt[v].name, ".done"},    {31'd0, done},    {31'd0, vt[v].done});
      chk({vt[v].name, ".err"},     {31'd0, err},     {31'd0, vt[v].err});
      chk({vt[v].name, ".cpu_rst"}, {31'd0, cpu_rst}, {31'd0, vt[v].crst});
    end

    // CPU release timing, then rearm from RUN.
    begin
      logic [7:0] fr [7];
      fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
      do_reset();
      for (int i = 0; i < 7; i++) send_byte(fr[i]);
      chk("boot.cpu_rst_before_csum", {31'd0, cpu_rst}, 32'd1);
      send_byte(8'hEC);
      chk("boot.cpu_rst_after_csum", {31'd0, cpu_rst}, 32'd0);
      chk("boot.done_after_csum",    {31'd0, done},    32'd1);
      idle(2);
      send_byte(8'h11);
      send_byte(8'h22);
      idle(3);
      chk("run_junk.cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("run_junk.done",    {31'd0, done},    32'd1);
      chk("run_junk.nwr",     wr_q.size(),      32'd2);
      send_byte(8'hA5);
      chk("rearm.cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("rearm.done",    {31'd0, done},    32'd0);
      wr_q.delete();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h88);
      idle(2);
      chk("rearm.nwr",  wr_q.size(), 32'd1);
      if (wr_q.size() >= 1) chk("rearm.w0", wr_q[0], 32'h0000_ABCD);
      chk("rearm.done2", {31'd0, done}, 32'd1);
    end

    // Inter-byte timeout: error lands exactly on the 100th idle clock.
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h34);
    bus.in_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("timeout.err_at_99", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    chk("timeout.err_at_100", {31'd0, err},     32'd1);
    chk("timeout.cpu_rst",    {31'd0, cpu_rst}, 32'd1);
    chk("timeout.done",       {31'd0, done},    32'd0);
    chk("timeout.nwr",        wr_q.size(),      32'd0);
    send_good_frame();
    idle(2);
    chk("after_timeout.nwr",  wr_q.size(),  32'd2);
    chk("after_timeout.done", {31'd0, done}, 32'd1);
    chk("after_timeout.err",  {31'd0, err},  32'd0);

    // Reset mid-frame while the write port still holds the last word.
    wr_q.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h34);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    rst = 1'b0;
    idle(3);
    chk("midrst.nwr", wr_q.size(), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h32);
    idle(2);
    chk("midrst.new_nwr", wr_q.size(), 32'd1);
    if (wr_q.size() >= 1) chk("midrst.new_w0", wr_q[0], 32'h0000_5678);
    chk("midrst.done", {31'd0, done}, 32'd1);

    // Random frames against a frame-level model of the expected writes and outcome.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int unsigned kind, cnt, njunk;
      logic [15:0] words [$];
      logic [31:0] exp_wr [$];
      logic [7:0]  sum, jb;
      logic [15:0] c16;
      bit          valid, bad;

      kind = $urandom_range(0, 9);
      if (kind == 0)      cnt = 0;
      else if (kind == 1) cnt = 8193 + $urandom_range(0, 1000);
      else                cnt = $urandom_range(1, 5);
      valid = (cnt >= 1 && cnt <= 8192);
      bad   = ($urandom_range(0, 3) == 0);
      words.delete();
      exp_wr.delete();
      sum = 8'h00;
      if (valid) begin
        for (int unsigned i = 0; i < cnt; i++) begin
          words.push_back(16'($urandom));
          exp_wr.push_back({16'(i * 2), words[i]});
          sum = sum + words[i][7:0] + words[i][15:8];
        end
      end

      wr_q.delete();
      njunk = $urandom_range(0, 2);
      for (int unsigned j = 0; j < njunk; j++) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        send_byte(jb);
      end
      c16 = 16'(cnt);
      send_byte(8'hA5);
      send_byte(c16[7:0]);
      send_byte(c16[15:8]);
      if (valid) begin
        for (int unsigned i = 0; i < cnt; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
          send_byte(words[i][7:0]);
          send_byte(words[i][15:8]);
        end
        send_byte(bad ? 8'(8'h00 - sum + 8'($urandom_range(1, 255))) : 8'(8'h00 - sum));
      end
      idle(2);

      chk($sformatf("rand%0d.nwr", f), wr_q.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
        chk($sformatf("rand%0d.w%0d", f, i), wr_q[i], exp_wr[i]);
      chk($sformatf("rand%0d.err", f),     {31'd0, err},     {31'd0, !(valid && !bad)});
      chk($sformatf("rand%0d.done", f),    {31'd0, done},    {31'd0, (valid && !bad)});
      chk($sformatf("rand%0d.cpu_rst", f), {31'd0, cpu_rst}, {31'd0, !(valid && !bad)});
    end

    chk("pgm_we_with_cpu_running", bad_we, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/j1_boot_loader.md
Name: j1_boot_loader

Overview:
Boot sequencer for the j1 CPU. It holds the CPU in reset and receives a framed program image from a byte stream (UART receiver or similar). It writes the image into j1 program memory through the pgm_addr/pgm_data/pgm_we port, then releases the CPU. Sits between the host-link byte source and the j1 instance. Its cpu_rst_o drives the j1 sys_rst_i, so pgm writes never collide with instruction fetch.

Parameters:
MAX_WORDS, 8192, largest accepted image in 16-bit words (j1 program RAM depth).
TIMEOUT, 1000000, max idle clocks between bytes inside a frame; 0 disables timeout.
REARM, 1, 1 = a sync byte received while the CPU runs restarts loading; 0 = input ignored after a successful load until sys_rst_i.

Ports:
sys_clk_i  in  1  clock; all logic on rising edge.
sys_rst_i  in  1  synchronous, active-high reset.
in_data  in  8  received byte.
in_valid  in  1  in_data valid; a byte is accepted when in_valid & in_ready.
in_ready  out  1  loader can accept a byte.
cpu_rst_o  out  1  reset to j1; 1 = CPU held.
pgm_addr  out  16  program memory byte address (word index << 1, bit 0 = 0).
pgm_data  out  16  program word.
pgm_we  out  1  one-cycle write strobe.
load_done  out  1  last load succeeded; CPU running.
load_err  out  1  last frame failed (sticky until next sync accepted).

Behaviour:
- Frame format: 0xA5 sync, COUNT low byte, COUNT high byte (COUNT in words), 2*COUNT data bytes (each word low byte first), CSUM byte. Valid frame: 8-bit sum of all data bytes plus CSUM == 0x00.
- Reset (sys_rst_i=1, any state, including mid-frame): state SYNC, cpu_rst_o=1, pgm_we=0, pgm_addr=0, pgm_data=0, load_done=0, load_err=0, in_ready=0 during reset, word index, sum and timer cleared. The frame in progress is abandoned.
- States: SYNC, CNTL, CNTH, DLO, DHI, CSUM, RUN. in_ready=1 in every state except RUN with REARM=0.
- SYNC: bytes other than 0xA5 are discarded. On 0xA5: load_err<=0, sum<=0, index<=0, go to CNTL.
- CNTL: latch the count low byte. CNTH: latch the count high byte. If COUNT==0 or COUNT>MAX_WORDS, set load_err=1 and go to SYNC. Otherwise go to DLO.
- DLO: hold the byte and add it to sum. DHI: add the byte to sum. On the next clock, pgm_we=1 for exactly one cycle with pgm_addr={index[14:0],1'b0} and pgm_data={hi,lo}, and index increments. After DHI, go to DLO if index+1<COUNT, otherwise go to CSUM.
- The write pulse overlaps acceptance of the next byte; no back-pressure is needed at full byte rate. Byte-per-cycle input is legal.
- CSUM: if (sum+byte)[7:0]==0, go to RUN on the next clock with cpu_rst_o=0 and load_done=1. Otherwise set load_err=1, keep cpu_rst_o=1, go to SYNC. Memory contents are undefined after a failed frame.
- RUN: cpu_rst_o=0. With REARM=1, non-0xA5 bytes are discarded. A 0xA5 sets cpu_rst_o=1 and load_done=0 on the next clock and enters CNTL, as in SYNC.
- Timeout: the timer clears on every accepted byte and increments every clock in CNTL..CSUM. When it reaches TIMEOUT (TIMEOUT≠0): load_err=1, go to SYNC, cpu_rst_o stays 1. The timer is inactive in SYNC and RUN.
- cpu_rst_o=1 whenever pgm_we can assert. pgm_we is never asserted in SYNC after an error, or in RUN.
- COUNT is 16 bits; sum is 8 bits with wrap; the index counter is 16 bits internally and is compared against COUNT.

Test Plan:
- Good load: A5 02 00 34 12 78 56 EC. Required: pgm_we at 0x0000/0x1234, then 0x0002/0x5678. cpu_rst_o falls one clock after EC is accepted; load_done=1, load_err=0.
- Bad checksum: same frame with last byte ED. Required: both writes occur, load_err=1, cpu_rst_o stays 1, load_done=0. A following good frame clears load_err and boots.
- Sync hunt and back-to-back: bytes 00 FF 5A, then the good frame with in_valid high every cycle. Required: junk ignored, 2 writes, boot.
- Count limits: A5 00 00 gives load_err=1 with no pgm_we. A5 01 20 (0x2001 > 8192) gives load_err=1 with no pgm_we.
- Timeout, with TIMEOUT=100: A5 02 00 34, then idle for 100 clocks. Required: load_err=1 at that clock, state SYNC, a fresh frame then loads.
- Reset/rearm:
  - sys_rst_i pulse after A5 01 00 34. Required: all outputs at reset values, no pgm_we; a new frame succeeds.
  - In RUN, bytes 11 22 give no effect. Byte A5 gives cpu_rst_o=1 and load_done=0 on the next clock.
